// File: rtl/tt_uart_tx_frontend_if.sv
// Pin-side bundle for the UART transmit front-end: write port, enable and
// line/status outputs. The top-level pins drive the master side.
interface tt_uart_tx_frontend_if;
    logic       ena;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       tx;
    logic       busy;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output ena, wr_data, wr_strobe,
        input  tx, busy, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  ena, wr_data, wr_strobe,
        output tx, busy, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/tt_uart_tx_frontend.sv
// UART 8N1 transmit front-end: synchronised write strobe, small byte FIFO
// and a registered serialiser driving the tx pin.
module tt_uart_tx_frontend #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    tt_uart_tx_frontend_if.slave bus
);
    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    state_t           r_state;
    logic [7:0]       r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;

    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_pop;
    logic w_push;
    logic w_baud_done;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_push_req  = r_s2 & ~r_s3 & bus.ena;
    assign w_pop       = (r_state == S_IDLE) & bus.ena & ~w_empty;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_baud_done = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.wr_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // Drive the next bit directly so tx stays a pure register.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_tt_uart_tx_frontend.sv
// Directed bench for the UART transmit front-end; a frame monitor decodes tx
// and checks each byte against a scoreboard filled when strobes are driven.
module tb_tt_uart_tx_frontend;
    localparam int unsigned CPB = 4;

    logic clk;
    logic rst_n;

    tt_uart_tx_frontend_if ifc ();

    tt_uart_tx_frontend #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    bit         mon_en = 1'b0;
    int         frames_seen = 0;
    int         start_cyc[64];
    logic [9:0] last_bits = '0;
    int         cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: mid-bit sampling relative to the detected falling edge.
    initial begin : monitor
        logic       tx_prev;
        logic [9:0] bits;
        logic [7:0] exp_b;
        tx_prev = 1'b1;
        bits    = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_prev && !ifc.tx) begin
                start_cyc[frames_seen % 64] = cyc;
                repeat (2) @(negedge clk);
                for (int b = 0; b < 10; b++) begin
                    bits[b] = ifc.tx;
                    if (b < 9) repeat (CPB) @(negedge clk);
                end
                last_bits = bits;
                check("frame_framing", 32'({bits[9], bits[0]}), 32'h2);
                check("frame_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("frame_data", 32'(bits[8:1]), 32'(exp_b));
                end
                frames_seen++;
                tx_prev = bits[9];
            end else begin
                tx_prev = ifc.tx;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input bit expect_accept);
        @(negedge clk);
        ifc.wr_data   = d;
        ifc.wr_strobe = 1'b1;
        if (expect_accept) sb.push_back(d);
        @(negedge clk);
        ifc.wr_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || ifc.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin : stim
        int cnt;
        int base;
        ifc.ena       = 1'b0;
        ifc.wr_data   = '0;
        ifc.wr_strobe = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(ifc.tx), 32'd1);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_empty", 32'(ifc.fifo_empty), 32'd1);
        check("rst_full", 32'(ifc.fifo_full), 32'd0);
        check("rst_overflow", 32'(ifc.overflow), 32'd0);
        rst_n = 1'b1;

        // Strobe with ena low is ignored.
        push_byte(8'h77, 1'b0);
        repeat (4) @(negedge clk);
        check("ena0_empty", 32'(ifc.fifo_empty), 32'd1);
        check("ena0_busy", 32'(ifc.busy), 32'd0);
        check("ena0_overflow", 32'(ifc.overflow), 32'd0);

        // Reset in the middle of a frame with one more byte queued.
        ifc.ena = 1'b1;
        push_byte(8'h5A, 1'b0);
        push_byte(8'h66, 1'b0);
        repeat (8) @(negedge clk);
        check("midrst_pre_busy", 32'(ifc.busy), 32'd1);
        check("midrst_pre_empty", 32'(ifc.fifo_empty), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(ifc.tx), 32'd1);
        check("midrst_busy", 32'(ifc.busy), 32'd0);
        check("midrst_empty", 32'(ifc.fifo_empty), 32'd1);
        check("midrst_overflow", 32'(ifc.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.tx === 1'b1) cnt++;
        end
        check("postrst_tx_high_cycles", 32'(cnt), 32'd20);
        check("postrst_busy", 32'(ifc.busy), 32'd0);

        mon_en = 1'b1;

        // Single byte: latency, bit pattern and busy width.
        @(negedge clk);
        ifc.wr_data   = 8'hA5;
        ifc.wr_strobe = 1'b1;
        sb.push_back(8'hA5);
        @(negedge clk);
        ifc.wr_strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("single_tx_before", 32'(ifc.tx), 32'd1);
        check("single_pushed", 32'(ifc.fifo_empty), 32'd0);
        @(negedge clk);
        check("single_start_tx", 32'(ifc.tx), 32'd0);
        check("single_start_busy", 32'(ifc.busy), 32'd1);
        cnt = 0;
        do begin
            cnt++;
            @(negedge clk);
        end while (ifc.busy && cnt < 100);
        check("single_busy_cycles", 32'(cnt), 32'd40);
        check("single_bits", 32'(last_bits), 32'h34A);

        // Back-to-back frames.
        base = frames_seen;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        push_byte(8'h3C, 1'b1);
        wait_frames("b2b", base + 3, 400);
        check("b2b_empty_after_pop3", 32'(ifc.fifo_empty), 32'd1);
        wait_drain("b2b", 200);
        check("b2b_gap1", 32'(start_cyc[(base + 1) % 64] - start_cyc[base % 64]), 32'(10 * CPB + 1));
        check("b2b_gap2", 32'(start_cyc[(base + 2) % 64] - start_cyc[(base + 1) % 64]), 32'(10 * CPB + 1));

        // Overflow: fill behind a running frame, then one extra push.
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        push_byte(8'h04, 1'b1);
        check("ovf_not_full_at3", 32'(ifc.fifo_full), 32'd0);
        push_byte(8'h05, 1'b1);
        check("ovf_full_at4", 32'(ifc.fifo_full), 32'd1);
        check("ovf_clear_at4", 32'(ifc.overflow), 32'd0);
        push_byte(8'h06, 1'b0);
        check("ovf_set", 32'(ifc.overflow), 32'd1);
        check("ovf_still_full", 32'(ifc.fifo_full), 32'd1);
        wait_drain("ovf", 600);
        check("ovf_sticky", 32'(ifc.overflow), 32'd1);
        check("ovf_drained_empty", 32'(ifc.fifo_empty), 32'd1);

        // Fresh start, then ena drop mid-frame and push landing on the pop cycle.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_overflow", 32'(ifc.overflow), 32'd0);
        base = frames_seen;
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b1);
        check("hold_full", 32'(ifc.fifo_full), 32'd1);
        check("hold_busy_mid", 32'(ifc.busy), 32'd1);
        ifc.ena = 1'b0;
        cnt = 0;
        while (ifc.busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("hold_frame_end_timeout", 32'(cnt < 100), 32'd1);
        repeat (20) @(negedge clk);
        check("hold_idle_busy", 32'(ifc.busy), 32'd0);
        check("hold_idle_tx", 32'(ifc.tx), 32'd1);
        check("hold_still_full", 32'(ifc.fifo_full), 32'd1);
        check("hold_one_frame", 32'(frames_seen - base), 32'd1);

        @(negedge clk);
        ifc.wr_data   = 8'h66;
        ifc.wr_strobe = 1'b1;
        sb.push_back(8'h66);
        @(negedge clk);
        ifc.wr_strobe = 1'b0;
        @(negedge clk);
        ifc.ena = 1'b1;
        @(negedge clk);
        check("pushpop_full", 32'(ifc.fifo_full), 32'd1);
        check("pushpop_overflow", 32'(ifc.overflow), 32'd0);
        check("pushpop_busy", 32'(ifc.busy), 32'd1);
        wait_drain("pushpop", 800);
        check("pushpop_empty", 32'(ifc.fifo_empty), 32'd1);
        check("pushpop_frames", 32'(frames_seen - base), 32'd6);
        check("pushpop_overflow_end", 32'(ifc.overflow), 32'd0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
